block_packer_8x8: RTL and testbench

Raster-to-block front end for the 8x8 matrix multiplier. It accepts an 8-bit grayscale pixel stream in raster order and buffers one band of 8 image rows. It then emits that band as a sequence of 8x8 blocks, each packed into a 512-bit word in the multiplier's `A`/`B` operand layout, under a valid/ready handshake. The downstream controller consumes `block_out` and sequences the multiplier's `Enable`.

---
 rtl/block_packer_8x8.sv | 140 ++++++++++++++
 tb/tb_block_packer_8x8.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_packer_8x8.sv
// Raster-to-block front end: buffers one 8-row band of an 8-bit pixel stream
// and emits it as 8x8 blocks packed into 512-bit operand words.
//
// state | meaning
// FILL  | accepting pixels into the band buffer
// LOAD  | gathering block blk_idx from the band into block_out
// OUT   | presenting block_out until the downstream takes it
module block_packer_8x8 #(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64
) (
  input  logic         Clock,
  input  logic         reset,
  input  logic [7:0]   pix_in,
  input  logic         pix_valid,
  input  logic         pix_sof,
  output logic         pix_ready,
  output logic [511:0] block_out,
  output logic         block_valid,
  input  logic         block_ready,
  output logic [4:0]   block_col,
  output logic [4:0]   block_row,
  output logic         block_last,
  output logic         sof_err
);

  localparam int            CW        = $clog2(IMG_WIDTH);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
  localparam logic [4:0]    BLK_LAST  = 5'(IMG_WIDTH / 8 - 1);
  localparam logic [4:0]    BAND_LAST = 5'(IMG_HEIGHT / 8 - 1);

  typedef enum logic [1:0] {FILL, LOAD, OUT} state_t;
  state_t state, state_nxt;

  logic [7:0]    band [8][IMG_WIDTH];
  logic [2:0]    row_cnt;
  logic [CW-1:0] col_cnt;
  logic [4:0]    band_cnt;
  logic [4:0]    blk_idx;

  logic          accept;
  logic          sof_restart;
  logic          band_done;
  logic          xfer;
  logic          drain_done;
  logic [2:0]    wr_row;
  logic [CW-1:0] wr_col;
  logic [CW-1:0] blk_base;
  logic [511:0]  blk_gather;

  assign accept      = (state == FILL) && pix_valid && pix_ready;
  // A start-of-frame anywhere but the very first slot of band 0 restarts the frame.
  assign sof_restart = accept && pix_sof &&
                       !(row_cnt == 3'd0 && col_cnt == '0 && band_cnt == 5'd0);
  assign band_done   = accept && !sof_restart && (row_cnt == 3'd7) && (col_cnt == COL_LAST);
  assign xfer        = (state == OUT) && block_valid && block_ready;
  assign drain_done  = xfer && (blk_idx == BLK_LAST);

  assign wr_row   = sof_restart ? 3'd0 : row_cnt;
  assign wr_col   = sof_restart ? '0 : col_cnt;
  assign blk_base = CW'({blk_idx, 3'b000});

  for (genvar gr = 0; gr < 8; gr++) begin : g_row
    for (genvar gc = 0; gc < 8; gc++) begin : g_col
      assign blk_gather[(gr*8+gc)*8 +: 8] = band[gr][blk_base + CW'(gc)];
    end
  end

  always_ff @(posedge Clock or posedge reset) begin
    if (reset) state <= FILL;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (band_done) state_nxt = LOAD;
      LOAD:    state_nxt = OUT;
      OUT:     if (xfer) state_nxt = drain_done ? FILL : LOAD;
      default: state_nxt = FILL;
    endcase
  end

  // Band storage needs no reset: counters define which bytes are live.
  always_ff @(posedge Clock) begin
    if (accept) band[wr_row][wr_col] <= pix_in;
  end

  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      row_cnt     <= '0;
      col_cnt     <= '0;
      band_cnt    <= '0;
      blk_idx     <= '0;
      pix_ready   <= 1'b0;
      block_valid <= 1'b0;
      block_out   <= '0;
      block_col   <= '0;
      block_row   <= '0;
      block_last  <= 1'b0;
      sof_err     <= 1'b0;
    end else begin
      pix_ready   <= (state_nxt == FILL);
      block_valid <= (state_nxt == OUT);

      if (sof_restart) begin
        row_cnt  <= 3'd0;
        col_cnt  <= CW'(1);
        band_cnt <= 5'd0;
        sof_err  <= 1'b1;
      end else if (accept) begin
        if (col_cnt == COL_LAST) begin
          col_cnt <= '0;
          row_cnt <= row_cnt + 3'd1;
        end else begin
          col_cnt <= col_cnt + CW'(1);
        end
        if (band_done) blk_idx <= '0;
      end

      if (state == LOAD) begin
        block_out  <= blk_gather;
        block_col  <= blk_idx;
        block_row  <= band_cnt;
        block_last <= (blk_idx == BLK_LAST) && (band_cnt == BAND_LAST);
      end

      if (xfer) begin
        if (drain_done) begin
          row_cnt  <= '0;
          col_cnt  <= '0;
          band_cnt <= (band_cnt == BAND_LAST) ? 5'd0 : band_cnt + 5'd1;
        end else begin
          blk_idx <= blk_idx + 5'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_block_packer_8x8.sv
// Bench for block_packer_8x8: scoreboard against an image-level reference
// model, fixed byte-position vectors, and hand-built handshake sequences.
module tb_block_packer_8x8;

  logic         Clock;
  logic         reset;
  logic [7:0]   pix_in;
  logic         pix_valid;
  logic         pix_sof;
  logic         pix_ready;
  logic [511:0] block_out;
  logic         block_valid;
  logic         block_ready;
  logic [4:0]   block_col;
  logic [4:0]   block_row;
  logic         block_last;
  logic         sof_err;

  block_packer_8x8 #(.IMG_WIDTH(64), .IMG_HEIGHT(64)) dut (
    .Clock(Clock), .reset(reset),
    .pix_in(pix_in), .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_ready(pix_ready),
    .block_out(block_out), .block_valid(block_valid), .block_ready(block_ready),
    .block_col(block_col), .block_row(block_row), .block_last(block_last),
    .sof_err(sof_err)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [511:0] data;
    logic [4:0]   col;
    logic [4:0]   row;
    logic         last;
  } blk_t;

  typedef struct {
    int         blk;
    int         r;
    int         c;
    logic [7:0] exp_px;
  } vec_t;

  blk_t         exp_q[$];
  logic [7:0]   mband [512];
  int           mn;
  int           mband_i;
  logic         merr;
  logic [511:0] cap_data [32];
  logic [4:0]   cap_row [32];
  int           blk_count;
  int           last_count;
  logic         hold_prev;
  logic         rdy_rand;
  vec_t         tbl [10];

  task automatic check(input string name, input logic [511:0] got, input logic [511:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Reference: the band is a 512-pixel raster; block k holds columns k*8..k*8+7.
  task automatic model_accept(input logic [7:0] px, input logic sof);
    blk_t b;
    if (sof && !(mn == 0 && mband_i == 0)) begin
      mn = 0; mband_i = 0; merr = 1'b1;
    end
    mband[mn] = px;
    mn++;
    if (mn == 512) begin
      for (int k = 0; k < 8; k++) begin
        b.data = '0;
        for (int r = 0; r < 8; r++)
          for (int c = 0; c < 8; c++)
            b.data[(r*8+c)*8 +: 8] = mband[r*64 + k*8 + c];
        b.col  = 5'(k);
        b.row  = 5'(mband_i);
        b.last = (k == 7) && (mband_i == 7);
        exp_q.push_back(b);
      end
      mband_i = (mband_i + 1) % 8;
      mn = 0;
    end
  endtask

  always @(negedge Clock) begin
    if (reset) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) check("hold_valid", block_valid, 1'b1);
      if (exp_q.size() != 0) check("ready_while_drain", pix_ready, 1'b0);
      if (pix_valid && pix_ready) model_accept(pix_in, pix_sof);
      if (block_valid) begin
        check("block_expected", 1'(exp_q.size() != 0), 1'b1);
        if (exp_q.size() != 0) begin
          check("block_data", block_out, exp_q[0].data);
          check("block_col", block_col, exp_q[0].col);
          check("block_row", block_row, exp_q[0].row);
          check("block_last", block_last, exp_q[0].last);
        end
        if (block_ready) begin
          cap_data[block_col] = block_out;
          cap_row[block_col]  = block_row;
          blk_count++;
          if (block_last) last_count++;
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
      end
      hold_prev = block_valid && !block_ready;
    end
  end

  task automatic step();
    @(posedge Clock);
    #1;
    if (rdy_rand) block_ready = 1'($urandom_range(1, 0));
  endtask

  task automatic send_pixel(input logic [7:0] v, input logic s, input int gap_pct);
    logic acc;
    int   w;
    for (int g = 0; g < 8 && int'($urandom_range(99, 0)) < gap_pct; g++) step();
    pix_valid = 1'b1; pix_in = v; pix_sof = s;
    acc = 1'b0; w = 0;
    while (!acc && w < 400) begin
      acc = pix_ready;
      step();
      w++;
    end
    check("pix_accept", acc, 1'b1);
    pix_valid = 1'b0; pix_sof = 1'b0;
  endtask

  task automatic send_band(input bit ramp, input bit sof_first, input int gap_pct);
    for (int i = 0; i < 512; i++)
      send_pixel(ramp ? 8'(i) : 8'($urandom), sof_first && (i == 0), gap_pct);
  endtask

  task automatic wait_valid(input string name);
    int w = 0;
    while (!block_valid && w < 300) begin step(); w++; end
    check({name, "_valid_wait"}, block_valid, 1'b1);
  endtask

  task automatic wait_drain(input string name);
    int w = 0;
    while ((exp_q.size() != 0 || !pix_ready) && w < 3000) begin step(); w++; end
    check({name, "_drain"}, exp_q.size(), 0);
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_pix_ready"}, pix_ready, 1'b0);
    check({name, "_block_valid"}, block_valid, 1'b0);
    check({name, "_block_out"}, block_out, '0);
    check({name, "_block_col"}, block_col, 5'd0);
    check({name, "_block_row"}, block_row, 5'd0);
    check({name, "_block_last"}, block_last, 1'b0);
    check({name, "_sof_err"}, sof_err, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check_reset_vals("rst");
    exp_q.delete(); mn = 0; mband_i = 0; merr = 1'b0; hold_prev = 1'b0;
    step(); step();
    reset = 1'b0;
    check("ready_low_after_release", pix_ready, 1'b0);
    step();
    check("ready_rises", pix_ready, 1'b1);
  endtask

  task automatic run_table(input string name);
    for (int i = 0; i < 10; i++)
      check($sformatf("%s_tbl%0d", name, i),
            cap_data[tbl[i].blk][(tbl[i].r*8 + tbl[i].c)*8 +: 8], tbl[i].exp_px);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation still running, bad=%0d", bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Ramp band: byte(r,c) of block k = (r*64 + k*8 + c) mod 256
    tbl[0] = '{0, 0, 0, 8'd0};
    tbl[1] = '{0, 0, 7, 8'd7};
    tbl[2] = '{0, 1, 0, 8'd64};
    tbl[3] = '{0, 3, 5, 8'd197};
    tbl[4] = '{0, 7, 7, 8'd199};
    tbl[5] = '{3, 0, 0, 8'd24};
    tbl[6] = '{3, 4, 2, 8'd26};
    tbl[7] = '{5, 2, 1, 8'd169};
    tbl[8] = '{7, 7, 7, 8'd255};
    tbl[9] = '{7, 0, 0, 8'd56};

    reset = 1'b1; pix_valid = 1'b0; pix_in = '0; pix_sof = 1'b0;
    block_ready = 1'b1; rdy_rand = 1'b0;
    mn = 0; mband_i = 0; merr = 1'b0; hold_prev = 1'b0;
    blk_count = 0; last_count = 0;
    step(); step();
    do_reset();

    // Ramp band with continuous input and an always-ready sink
    send_band(1'b1, 1'b1, 0);
    check("s1_ready_falls", pix_ready, 1'b0);
    check("s1_valid_not_yet", block_valid, 1'b0);
    step();
    check("s1_valid_rises", block_valid, 1'b1);
    check("s1_first_col", block_col, 5'd0);
    check("s1_first_row", block_row, 5'd0);
    repeat (14) step();
    check("s1_ready_before_drain_end", pix_ready, 1'b0);
    step();
    check("s1_ready_after_drain", pix_ready, 1'b1);
    check("s1_drained", exp_q.size(), 0);
    run_table("s1");

    // Backpressure on block 2 of band 1
    block_ready = 1'b0;
    send_band(1'b1, 1'b0, 0);
    for (int k = 0; k < 8; k++) begin
      wait_valid("s2");
      if (k == 2) begin
        repeat (10) begin
          step();
          check("s2_hold_valid", block_valid, 1'b1);
          check("s2_hold_col", block_col, 5'd2);
          check("s2_hold_row", block_row, 5'd1);
          check("s2_hold_data", block_out, exp_q[0].data);
          check("s2_hold_pix_ready", pix_ready, 1'b0);
        end
        block_ready = 1'b1; step(); block_ready = 1'b0;
        check("s2_gap_after_release", block_valid, 1'b0);
        step();
        check("s2_next_valid", block_valid, 1'b1);
        check("s2_next_col", block_col, 5'd3);
      end else begin
        block_ready = 1'b1; step(); block_ready = 1'b0;
      end
    end
    check("s2_ready_after", pix_ready, 1'b1);
    check("s2_drained", exp_q.size(), 0);
    block_ready = 1'b1;

    // Full random frame with random sink readiness, then a second frame
    do_reset();
    rdy_rand = 1'b1; blk_count = 0; last_count = 0;
    for (int b = 0; b < 8; b++) send_band(1'b0, b == 0, 25);
    wait_drain("s3");
    check("s3_block_count", blk_count, 64);
    check("s3_last_count", last_count, 1);
    send_band(1'b0, 1'b1, 10);
    wait_drain("s3b");
    check("s3_restart_row", cap_row[0], 5'd0);
    check("s3b_block_count", blk_count, 72);
    rdy_rand = 1'b0; block_ready = 1'b1;

    // Gapped ramp must reproduce the ramp blocks
    do_reset();
    send_band(1'b1, 1'b1, 50);
    wait_drain("s4");
    run_table("s4");

    // Start-of-frame in mid band
    do_reset();
    for (int i = 0; i < 100; i++) send_pixel(8'($urandom), i == 0, 0);
    check("s5_no_err_yet", sof_err, 1'b0);
    send_pixel(8'hAA, 1'b1, 0);
    check("s5_err_set", sof_err, 1'b1);
    for (int i = 0; i < 511; i++) send_pixel(8'($urandom), 1'b0, 0);
    wait_drain("s5");
    check("s5_first_byte", cap_data[0][7:0], 8'hAA);
    check("s5_first_row", cap_row[0], 5'd0);
    check("s5_err_sticky", sof_err, 1'b1);

    // Reset while block 4 is being offered
    do_reset();
    block_ready = 1'b0;
    send_band(1'b1, 1'b1, 0);
    for (int k = 0; k < 4; k++) begin
      wait_valid("s6");
      block_ready = 1'b1; step(); block_ready = 1'b0;
    end
    wait_valid("s6_b4");
    check("s6_in_block4", block_col, 5'd4);
    do_reset();
    block_ready = 1'b1;
    send_band(1'b1, 1'b1, 0);
    step();
    check("s6_first_valid", block_valid, 1'b1);
    check("s6_first_col", block_col, 5'd0);
    wait_drain("s6");
    run_table("s6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
